// File: rtl/seq_safe_ctrl.sv
// Sequential code lock: digits are checked one per enter strobe, and repeated wrong codes trigger a timed lockout.
// Optional SAFE_AUTO_RELOCK_EN: an open safe closes itself after RELOCK_CYC cycles without lock.
//
// state   | meaning
// ENTRY   | collecting code digits, L0=0 L1=0
// OPEN    | correct code accepted, L0=1
// LOCKOUT | MAX_TRIES wrong codes, L1=1 for LOCKOUT_CYC cycles
module seq_safe_ctrl #(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] CODE = 16'hEC39,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int RELOCK_CYC  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] S,
    input  logic               enter,
    input  logic               lock,
    output logic               L0,
    output logic               L1,
    output logic [3:0]         tries_left
);

    localparam int CODE_W = DIGIT_W * CODE_LEN;
    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int LOCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    localparam logic [1:0] ENTRY   = 2'd0;
    localparam logic [1:0] OPEN    = 2'd1;
    localparam logic [1:0] LOCKOUT = 2'd2;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [3:0]        TRIES_MAX = 4'(MAX_TRIES);

    if (CODE_LEN < 1 || CODE_LEN > 8) begin : g_bad_code_len
        $error("CODE_LEN must be in 1..8");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("MAX_TRIES must be in 1..15");
    end
    if (LOCKOUT_CYC < 1) begin : g_bad_lockout
        $error("LOCKOUT_CYC must be >= 1");
    end
    if (RELOCK_CYC < 1) begin : g_bad_relock
        $error("RELOCK_CYC must be >= 1");
    end

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic               mismatch;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [CODE_W-1:0]  code_sh;
    logic [DIGIT_W-1:0] exp_digit;
    logic               mm_now;

`ifdef SAFE_AUTO_RELOCK_EN
    localparam int RELOCK_W = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
    localparam logic [RELOCK_W-1:0] RELOCK_LOAD = RELOCK_W'(RELOCK_CYC - 1);
    logic [RELOCK_W-1:0] relock_cnt;
`endif

    // Current digit is shifted up to the MSBs so the first digit sits at index 0.
    always_comb begin
        code_sh   = CODE << (32'(idx) * DIGIT_W);
        exp_digit = code_sh[CODE_W-1 -: DIGIT_W];
        mm_now    = mismatch | (S != exp_digit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ENTRY;
            idx        <= '0;
            mismatch   <= 1'b0;
            tries_left <= TRIES_MAX;
            lock_cnt   <= '0;
            L0         <= 1'b0;
            L1         <= 1'b0;
`ifdef SAFE_AUTO_RELOCK_EN
            relock_cnt <= '0;
`endif
        end else begin
            case (state)
                ENTRY: begin
                    if (lock) begin
                        idx      <= '0;
                        mismatch <= 1'b0;
                    end else if (enter) begin
                        if (idx == IDX_LAST) begin
                            idx      <= '0;
                            mismatch <= 1'b0;
                            if (!mm_now) begin
                                state      <= OPEN;
                                L0         <= 1'b1;
                                tries_left <= TRIES_MAX;
`ifdef SAFE_AUTO_RELOCK_EN
                                relock_cnt <= RELOCK_LOAD;
`endif
                            end else if (tries_left <= 4'd1) begin
                                state      <= LOCKOUT;
                                L1         <= 1'b1;
                                tries_left <= 4'd0;
                                lock_cnt   <= LOCK_LOAD;
                            end else begin
                                tries_left <= tries_left - 4'd1;
                            end
                        end else begin
                            idx      <= idx + 1'b1;
                            mismatch <= mm_now;
                        end
                    end
                end
                OPEN: begin
                    if (lock) begin
                        state <= ENTRY;
                        L0    <= 1'b0;
                        idx   <= '0;
                    end
`ifdef SAFE_AUTO_RELOCK_EN
                    else if (relock_cnt == '0) begin
                        state <= ENTRY;
                        L0    <= 1'b0;
                        idx   <= '0;
                    end else begin
                        relock_cnt <= relock_cnt - 1'b1;
                    end
`endif
                end
                LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        state      <= ENTRY;
                        L1         <= 1'b0;
                        tries_left <= TRIES_MAX;
                        idx        <= '0;
                        mismatch   <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ENTRY;
                    idx      <= '0;
                    mismatch <= 1'b0;
                    L0       <= 1'b0;
                    L1       <= 1'b0;
                end
            endcase
        end
    end

endmodule
